bunny_hit_detector: RTL and testbench

Collision/hit stage for the bunny game, directly upstream of the life counter. It compares the bunny's lane and jump state against the active obstacle on each game tick and emits a single-clock `hit` pulse per new collision. After each hit it enforces a tick-counted invulnerability window, and it goes permanently quiet once the life counter reports `die`.

---
 rtl/bunny_game_pkg.sv | 6 +
 rtl/hit_invuln_timer.sv | 45 ++++
 rtl/bunny_hit_detector.sv | 62 ++++++
 tb/tb_bunny_hit_detector.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bunny_game_pkg.sv
// bunny_game_pkg: shared hit-stage state encoding and default constants for the bunny game.
package bunny_game_pkg;
  typedef enum logic [1:0] {ARMED, HIT, INVULN, DEAD} hit_state_t;
  localparam int BUNNY_COL_DEF    = 2;
  localparam int INVULN_TICKS_DEF = 8;
endpackage

// File: rtl/hit_invuln_timer.sv
// hit_invuln_timer: invulnerability tick counter with done flag; blink divider only when BUNNY_HIT_BLINK_EN is defined.
module hit_invuln_timer
  import bunny_game_pkg::*;
#(
  parameter int INVULN_TICKS = INVULN_TICKS_DEF,
  parameter int BLINK_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       die,
  input  hit_state_t state,
  output logic       done,
  output logic       blink
);
  logic       run;
  logic [7:0] cnt;
  if (INVULN_TICKS < 1 || INVULN_TICKS > 255 || BLINK_DIV < 1) begin : g_bad_param
    $error("hit_invuln_timer: INVULN_TICKS must be 1..255 and BLINK_DIV >= 1");
  end
  assign run  = (state == INVULN) & ~die;
  assign done = run & tick & (cnt == 8'd1);
  // Loaded while entering HIT so the window count is ready on the first INVULN tick.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (start) cnt <= 8'(INVULN_TICKS);
    else if (run & tick) cnt <= cnt - 8'd1;
`ifdef BUNNY_HIT_BLINK_EN
  logic [7:0] div;
  logic       hold, wrap;
  assign hold = (state == HIT) & ~die;
  assign wrap = div == 8'(BLINK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div   <= '0;
      blink <= 1'b0;
    end else begin
      div   <= start ? '0 : (run & tick) ? (wrap ? '0 : div + 8'd1) : div;
      blink <= start | (hold & blink) | (run & ~done & ((tick & wrap) ? ~blink : blink));
    end
`else
  assign blink = 1'b0;
`endif
endmodule

// File: rtl/bunny_hit_detector.sv
// bunny_hit_detector: tick-rate collision edge detector with invulnerability window and sticky death.
// Optional sprite blink output enabled by defining BUNNY_HIT_BLINK_EN.
module bunny_hit_detector
  import bunny_game_pkg::*;
#(
  parameter int ROW_W        = 2,
  parameter int COL_W        = 4,
  parameter int BUNNY_COL    = BUNNY_COL_DEF,
  parameter int INVULN_TICKS = INVULN_TICKS_DEF,
  parameter int BLINK_DIV    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [ROW_W-1:0] bunny_row,
  input  logic             bunny_jump,
  input  logic             obs_valid,
  input  logic [ROW_W-1:0] obs_row,
  input  logic [COL_W-1:0] obs_col,
  input  logic             die,
  output logic             hit,
  output logic             invuln,
  output logic             blink
);
  hit_state_t state, nxt;
  logic overlap, ov_q, new_col, start, done;
  assign overlap = obs_valid & (obs_col == COL_W'(BUNNY_COL)) & (obs_row == bunny_row) & ~bunny_jump;
  assign new_col = tick & overlap & ~ov_q;
  assign start   = (state == ARMED) & new_col & ~die;
  always_comb
    nxt = die              ? DEAD
        : state == ARMED  ? (new_col ? HIT : ARMED)
        : state == HIT    ? INVULN
        : state == INVULN ? (done ? ARMED : INVULN)
        : DEAD;
  // ov_q keeps tracking through INVULN so a held overlap cannot retrigger after the window.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= ARMED;
      ov_q   <= 1'b0;
      hit    <= 1'b0;
      invuln <= 1'b0;
    end else begin
      if (tick && state != DEAD) ov_q <= overlap;
      state  <= nxt;
      hit    <= nxt == HIT;
      invuln <= nxt == HIT || nxt == INVULN;
    end
  hit_invuln_timer #(
    .INVULN_TICKS(INVULN_TICKS),
    .BLINK_DIV   (BLINK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .start(start),
    .die  (die),
    .state(state),
    .done (done),
    .blink(blink)
  );
endmodule

// File: tb/tb_bunny_hit_detector.sv
// tb_bunny_hit_detector: scoreboard bench; per-clock expected {hit,invuln,blink} from a window-count model.
module tb_bunny_hit_detector;
  localparam int INV = 8;
  localparam int DIV = 2;
`ifdef BUNNY_HIT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  typedef struct {
    string      tag;
    logic [2:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, bunny_jump = 1'b0, obs_valid = 1'b0, die = 1'b0;
  logic [1:0] bunny_row = '0, obs_row = '0;
  logic [3:0] obs_col = '0;
  logic hit, invuln, blink;
  exp_t sb[$];
  string phase = "reset";
  int n_run = 0, n_fail = 0;
  int m_left = 0, m_k = 0;
  bit m_hit = 0, m_dead = 0, m_prev = 0;

  bunny_hit_detector dut (
    .clk(clk), .rst(rst), .tick(tick), .bunny_row(bunny_row), .bunny_jump(bunny_jump),
    .obs_valid(obs_valid), .obs_row(obs_row), .obs_col(obs_col), .die(die),
    .hit(hit), .invuln(invuln), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: {hit,invuln,blink} got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Model: window measured in ticks remaining; blink phase from ticks elapsed in the window.
  task automatic model_push();
    logic ov, v, b;
    exp_t e;
    ov = obs_valid && obs_col == 4'd2 && obs_row == bunny_row && !bunny_jump;
    if (!rst) begin
      m_dead = 0; m_hit = 0; m_left = 0; m_prev = 0; m_k = 0;
    end else if (m_dead || die) begin
      m_dead = 1; m_hit = 0; m_left = 0;
    end else begin
      if (m_hit) begin
        m_hit = 0; m_left = INV; m_k = 0;
      end else if (m_left > 0) begin
        if (tick) begin m_left--; m_k++; end
      end else if (tick && ov && !m_prev) begin
        m_hit = 1; m_k = 0;
      end
      if (tick) m_prev = ov;
    end
    v = m_hit || m_left > 0;
    b = BLINK_EN && v && ((m_k / DIV) % 2 == 0);
    e.tag = phase;
    e.v = {m_hit, v, b};
    sb.push_back(e);
  endtask

  task automatic step();
    model_push();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (3) step();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, {hit, invuln, blink}, e.v);
    end
  end

  initial begin
    step();
    step();
    rst = 1'b1;
    ticks(2);
    phase = "single";
    bunny_row = 2'd1; obs_row = 2'd1; obs_col = 4'd2; obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(10);
    phase = "jump";
    bunny_jump = 1'b1; obs_valid = 1'b1;
    ticks(3);
    obs_valid = 1'b0;
    ticks(1);
    bunny_jump = 1'b0;
    ticks(1);
    phase = "persist";
    obs_valid = 1'b1;
    ticks(20);
    obs_valid = 1'b0;
    ticks(1);
    phase = "persist_rehit";
    obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(10);
    phase = "in_window";
    obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(2);
    obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(5);
    phase = "after_window";
    obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(2);
    phase = "async_rst";
    rst = 1'b0;
    #1;
    chk("async_rst_now", {hit, invuln, blink}, 3'b000);
    step();
    step();
    rst = 1'b1;
    ticks(1);
    phase = "die";
    obs_valid = 1'b1; die = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(1);
    obs_valid = 1'b1;
    ticks(1);
    die = 1'b0; obs_valid = 1'b0;
    ticks(1);
    obs_valid = 1'b1;
    ticks(1);
    phase = "dead_rst";
    rst = 1'b0;
    step();
    rst = 1'b1; obs_valid = 1'b0;
    ticks(1);
    obs_valid = 1'b1;
    ticks(1);
    obs_valid = 1'b0;
    ticks(10);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
